// File: rtl/gate_bist_ctrl.sv
// -----------------------------------------------------------------------------
// gate_bist_ctrl
//
// Built-in self-test sequencer for the two-input basic-gate block.
//
// A start request makes the sequencer drive the gate block's a/b inputs through
// the vectors 00, 01, 10 and 11. After each vector it waits SETTLE cycles, then
// compares all seven gate results with the values it expects. It accumulates
// per-vector and per-gate failure information and reports a pass flag at the
// end of the run.
//
// Parameters
//   SETTLE       idle cycles between driving a vector and sampling (0..15)
//
// Ports
//   clk_in       clock, rising edge
//   rst_in       asynchronous active-high reset
//   start_in     run request, only honoured while idle
//   a_op, b_op   registered drive to the gate block inputs
//   *_in         the seven gate block results (not/and/nand/or/nor/xor/xnor)
//   busy_op      run in progress
//   done_op      one-cycle pulse at the end of a run
//   pass_op      last completed run had no mismatches
//   fail_vec_op  bit k set if vector {a,b}=k mismatched
//   err_mask_op  sticky per-gate mismatch mask:
//                [0] not [1] and [2] nand [3] or [4] nor [5] xor [6] xnor
// -----------------------------------------------------------------------------
module gate_bist_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       start_in,
  output logic       a_op,
  output logic       b_op,
  input  logic       not_in,
  input  logic       and_in,
  input  logic       nand_in,
  input  logic       or_in,
  input  logic       nor_in,
  input  logic       xor_in,
  input  logic       xnor_in,
  output logic       busy_op,
  output logic       done_op,
  output logic       pass_op,
  output logic [3:0] fail_vec_op,
  output logic [6:0] err_mask_op
);

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       pass_q, pass_d;
  logic [3:0] fail_vec_q, fail_vec_d;
  logic [6:0] err_mask_q, err_mask_d;

  logic [6:0] result;
  logic [6:0] expected;
  logic [6:0] mismatch;

  assign result = {xnor_in, xor_in, nor_in, or_in, nand_in, and_in, not_in};

  // Reference values for the vector currently on the gate block inputs.
  assign expected = {~(a_q ^ b_q), a_q ^ b_q, ~(a_q | b_q), a_q | b_q,
                     ~(a_q & b_q), a_q & b_q, ~a_q};

  // Case inequality makes an X or Z result count as a mismatch in simulation;
  // synthesis reduces it to an ordinary inequality.
  always_comb begin
    for (int i = 0; i < 7; i++) begin
      mismatch[i] = (result[i] !== expected[i]);
    end
  end

  always_comb begin
    // NOTE: every next-state signal takes its current value first, so no path
    // through the case statement leaves one unassigned and infers a latch.
    state_d    = state_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    pass_d     = pass_q;
    fail_vec_d = fail_vec_q;
    err_mask_d = err_mask_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_in) begin
          state_d    = S_APPLY;
          vec_d      = 2'd0;
          a_d        = 1'b0;
          b_d        = 1'b0;
          pass_d     = 1'b0;
          fail_vec_d = 4'd0;
          err_mask_d = 7'd0;
        end
      end

      S_APPLY: begin
        cnt_d   = SETTLE_C;
        state_d = (SETTLE_C != 4'd0) ? S_WAIT : S_CHECK;
      end

      // The counter holds the number of WAIT cycles still to spend, including
      // the current one, so leaving at 1 gives exactly SETTLE cycles.
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        err_mask_d = err_mask_q | mismatch;
        if (|mismatch) begin
          fail_vec_d[vec_q] = 1'b1;
        end
        if (vec_q == 2'd3) begin
          state_d = S_DONE;
          a_d     = 1'b0;
          b_d     = 1'b0;
          pass_d  = (fail_vec_d == 4'd0);
        end else begin
          // The next vector goes out on this same edge, so APPLY already sees it.
          state_d = S_APPLY;
          vec_d   = vec_q + 2'd1;
          a_d     = vec_d[1];
          b_d     = vec_d[0];
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      vec_q      <= 2'd0;
      cnt_q      <= 4'd0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      pass_q     <= 1'b0;
      fail_vec_q <= 4'd0;
      err_mask_q <= 7'd0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      pass_q     <= pass_d;
      fail_vec_q <= fail_vec_d;
      err_mask_q <= err_mask_d;
    end
  end

  assign a_op        = a_q;
  assign b_op        = b_q;
  assign busy_op     = (state_q == S_APPLY) || (state_q == S_WAIT) ||
                       (state_q == S_CHECK);
  assign done_op     = (state_q == S_DONE);
  assign pass_op     = pass_q;
  assign fail_vec_op = fail_vec_q;
  assign err_mask_op = err_mask_q;

endmodule

// File: doc/gate_bist_ctrl.md
# gate_bist_ctrl

Built-in self-test sequencer for the two-input basic-gate block (NOT/AND/NAND/OR/NOR/XOR/XNOR). On a start pulse it drives the gate block's `a`/`b` inputs through all four input combinations in order. It waits a programmable settle time after each vector and compares all seven gate outputs against internally computed expected values. It then reports per-vector and per-gate failure information plus an overall pass flag. It sits between the lab test harness (switches/LEDs or testbench) and the gate block instance.

## Interface

Parameters:
- `SETTLE`, default 1: idle cycles between driving a vector and sampling results; legal range 0..15.

Ports:
- `clk_in` input 1: single clock, all state updates on rising edge.
- `rst_in` input 1: asynchronous, active-high reset.
- `start_in` input 1: run request; sampled only in IDLE.
- `a_op` output 1: drives gate block input `a`; registered.
- `b_op` output 1: drives gate block input `b`; registered.
- `not_in`, `and_in`, `nand_in`, `or_in`, `nor_in`, `xor_in`, `xnor_in` input 1 each: gate block results.
- `busy_op` output 1: high while a run is in progress (APPLY/WAIT/CHECK).
- `done_op` output 1: one-cycle pulse at end of run.
- `pass_op` output 1: 1 when the last completed run had no mismatches; held until the next start is accepted.
- `fail_vec_op` output 4: bit k set if vector k ({a,b}=k) had any mismatch.
- `err_mask_op` output 7: sticky OR of mismatching outputs over the run. Bit order: [0] not, [1] and, [2] nand, [3] or, [4] nor, [5] xor, [6] xnor.

## Operation

- FSM states: IDLE, APPLY, WAIT, CHECK, DONE. A 2-bit vector index `vec` and a settle counter of width 4 are used.
- **IDLE**
  - When `start_in`=1, go to APPLY.
  - On that edge: set `vec`=0, `a_op`=0, `b_op`=0, clear `fail_vec_op`, `err_mask_op` and `pass_op`.
  - Otherwise stay in IDLE.
- **APPLY**
  - `a_op`=`vec[1]`, `b_op`=`vec[0]` are already valid.
  - Load the settle counter with SETTLE.
  - Go to WAIT if SETTLE>0, else go to CHECK.
- **WAIT**
  - Decrement the counter each cycle.
  - When the counter reaches 1, go to CHECK. WAIT therefore lasts exactly SETTLE cycles.
- **CHECK**: compare inputs with the expected values for a=`a_op`, b=`b_op`.
  - Expected values: not=~a, and=a&b, nand=~(a&b), or=a|b, nor=~(a|b), xor=a^b, xnor=~(a^b).
  - OR the mismatch bits into `err_mask_op`.
  - Set `fail_vec_op[vec]` if any mismatch occurred.
  - If `vec`=3, go to DONE.
  - Otherwise set `vec`+1 and drive the new `a_op`/`b_op` on the same edge, then go to APPLY.
- **DONE**
  - Assert `done_op` for this one cycle.
  - `pass_op` = (`fail_vec_op`==0), registered on entry.
  - `a_op`=`b_op`=0.
  - Always return to IDLE.
- `start_in` is ignored in every state except IDLE, with no queuing.
- X or Z on result inputs is treated as a mismatch. Use case-inequality in simulation; synthesis compares normally.
- Vector order is fixed: 00, 01, 10, 11.

## Timing

- Reset values: `a_op`=0, `b_op`=0, `busy_op`=0, `done_op`=0, `pass_op`=0, `fail_vec_op`=0, `err_mask_op`=0, state=IDLE, `vec`=0.
- Reset mid-run returns everything to reset values immediately (asynchronous). The next `start_in` performs a full run.
- `busy_op`=1 from the cycle after start acceptance until DONE is entered. It is 0 in DONE.
- Per vector: 1 APPLY + SETTLE WAIT + 1 CHECK cycles.
- Start-accept edge to DONE entry is 4·(SETTLE+2) cycles. Examples: SETTLE=1 gives 12; SETTLE=0 gives 8.
- Gate results are sampled at the CHECK edge, at least SETTLE+1 cycles after the vector changed.
- Status outputs (`fail_vec_op`, `err_mask_op`, `pass_op`) remain stable from DONE until the next accepted start.
- Back-to-back runs: the earliest next start is sampled in IDLE, one cycle after DONE.

## Test plan

- **Good gate block, SETTLE=1, one-cycle start pulse.**
  - `busy_op` rises the next cycle.
  - `a_op`/`b_op` sequence is 00, 01, 10, 11, each held 3 cycles.
  - `done_op` pulses 12 cycles after acceptance.
  - `pass_op`=1, `fail_vec_op`=4'b0000, `err_mask_op`=7'b0000000.
- **Fault injection: `xor_in` stuck at 0.**
  - `fail_vec_op`=4'b0110, `err_mask_op`=7'b0100000, `pass_op`=0.
- **Fault injection: `nand_in` tied to `and_in` (inverted wiring).**
  - `fail_vec_op`=4'b1111, `err_mask_op`=7'b0000100, `pass_op`=0.
- **Start held high for 20 cycles and re-pulsed while busy.**
  - Exactly one run per IDLE visit.
  - A second run begins one cycle after DONE if start is still high.
  - No extra `done_op` pulses.
- **Reset asserted during vector 2 WAIT.**
  - All outputs are immediately 0 and state is IDLE.
  - A subsequent start gives a full 4-vector run with correct pass.
- **SETTLE=0 build.**
  - No WAIT cycles.
  - `done_op` 8 cycles after acceptance.
  - Results identical to the SETTLE=1 good-DUT case.
